lsu_axil_master: RTL and testbench

- Load/store unit bus front-end: accepts one memory request at a time from the execute stage.
- Converts each request into a single AXI-lite read (AR/R) or write (AW/W/B) transaction toward the data-memory slave.
- Returns aligned, sign/zero-extended load data or a store completion on a valid/ready response port.
- Sits directly upstream of the DPI-backed memory slave, driving its read-address, read-data, write-address, write-data and write-response channels.

---
 rtl/lsu_axil_master.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu_axil_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axil_master.sv
// lsu_axil_master
// ---------------
// Load/store unit bus front-end. Takes one memory request at a time from the
// execute stage and turns it into a single AXI-lite read (AR/R) or write
// (AW/W/B) transaction. The result goes back on a valid/ready response port.
// For a load this is aligned, sign- or zero-extended data. For a store it is a
// completion carrying zero data.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   req_*             request port (valid/ready), one outstanding at a time
//   resp_*            response port (valid/ready); rdata is 0 for stores
//   ar*/r*            AXI-lite read address / read data channels
//   aw*/w*/b*         AXI-lite write address / write data / write response
//
// Handshake rule (every channel): a transfer happens on a posedge where both
// valid and ready are high. A valid, once raised, stays high and its payload
// stays stable until that transfer. Every bus and response output is driven
// from registers or the current state only, never directly from an input.
//
// Optional build macro
//   LSU_MISALIGN_CHECK_EN  when defined, a misaligned half or word request
//                          issues no bus transaction. It completes in one cycle
//                          with resp_err=1 and resp_rdata=0. When undefined,
//                          misaligned requests go out with truncated
//                          strobes/shifts.

module lsu_axil_master (
    input  logic        clk,
    input  logic        rst,
    // request port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    // response port
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // read address / data
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    // write address / data / response
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_misalign;
    logic [3:0]  w_strb_base;
    logic [31:0] w_rshift;
    logic [31:0] w_load_ext;

`ifdef LSU_MISALIGN_CHECK_EN
    // Half needs addr[0]==0. Word (size 2, and reserved size 3) needs addr[1:0]==0.
    assign w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Strobe before lane shifting. Size 3 is reserved and treated as a word.
    always_comb begin
        w_strb_base = 4'b1111;
        case (req_size)
            2'd0:    w_strb_base = 4'b0001;
            2'd1:    w_strb_base = 4'b0011;
            default: w_strb_base = 4'b1111;
        endcase
    end

    // Bring the addressed byte lane down to bit 0, then extend from the access
    // width. A misaligned half at offset 3 only has its low byte in range. The
    // zero-filled upper bits then act as the sign source, which drops the
    // out-of-range byte.
    assign w_rshift = rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_ext = w_rshift;
        case (r_size)
            2'd0:    w_load_ext = {{24{w_rshift[7]  & ~r_unsigned}}, w_rshift[7:0]};
            2'd1:    w_load_ext = {{16{w_rshift[15] & ~r_unsigned}}, w_rshift[15:0]};
            default: w_load_ext = w_rshift;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_misalign)   w_next = S_RESP;
                    else if (req_wen) w_next = S_W;
                    else              w_next = S_AR;
                end
            end
            S_AR:   if (arready) w_next = S_R;
            S_R:    if (rvalid)  w_next = S_RESP;
            // Each write channel counts as done once its own handshake has
            // completed, whether in an earlier cycle or in this one.
            S_W:    if ((r_aw_done || awready) && (r_w_done || wready)) w_next = S_B;
            S_B:    if (bvalid)  w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, write-channel progress and response capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_rdata    <= 32'd0;
                        r_err      <= w_misalign;
                        if (req_wen) begin
                            r_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                            r_wstrb <= w_strb_base << req_addr[1:0];
                        end
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        r_rdata <= w_load_ext;
                        r_err   <= (rresp != 2'b00);
                    end
                end
                S_W: begin
                    if (awready) r_aw_done <= 1'b1;
                    if (wready)  r_w_done  <= 1'b1;
                end
                S_B: begin
                    if (bvalid) begin
                        r_rdata <= 32'd0;
                        r_err   <= (bresp != 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign araddr     = {r_addr[31:2], 2'b00};
    assign arvalid    = (r_state == S_AR);
    assign rready     = (r_state == S_R);

    assign awaddr     = {r_addr[31:2], 2'b00};
    assign awvalid    = (r_state == S_W) && !r_aw_done;
    assign wdata      = r_wdata;
    assign wstrb      = r_wstrb;
    assign wvalid     = (r_state == S_W) && !r_w_done;
    assign bready     = (r_state == S_B);

endmodule

// File: tb/tb_lsu_axil_master.sv
module tb_lsu_axil_master;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  lsu_axil_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0;
    req_unsigned = 0; resp_ready = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
  endtask

  // Every output that should be quiet in IDLE
  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_quiet"}, {26'd0, resp_valid, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
  endtask

  // Response phase: hold resp_ready low for 'hold' cycles, then consume.
  // Called at the negedge where resp_valid is expected.
  task automatic take_resp(input string tag, input logic exp_err, input int hold);
    logic [31:0] exp_rd;
    exp_rd = exp_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_resp_rdata"}, resp_rdata, exp_rd);
      check({tag, "_resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      check({tag, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
      if (h == hold) resp_ready = 1;
      @(negedge clk);
    end
    resp_ready = 0;
    check_idle({tag, "_after"});
  endtask

  // Load with a scripted slave: ar_wait/r_wait stall cycles before each handshake.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rd, input logic [1:0] rr,
                         input int ar_wait, input int r_wait,
                         input logic [31:0] exp_rd, input logic exp_err);
    int cyc;
    exp_q.push_back(exp_rd);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_wen = 0; req_addr = addr; req_size = size; req_unsigned = uns;
    req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 0;
    cyc = 1;
    for (int k = 0; k <= ar_wait; k++) begin
      check({tag, "_arvalid"}, {31'd0, arvalid}, 32'd1);
      check({tag, "_araddr"}, araddr, {addr[31:2], 2'b00});
      if (k == ar_wait) arready = 1;
      @(negedge clk);
      cyc++;
    end
    arready = 0;
    for (int k = 0; k <= r_wait; k++) begin
      check({tag, "_rready"}, {30'd0, rready, arvalid}, 32'd2);
      if (k == r_wait) begin
        rvalid = 1; rdata = rd; rresp = rr;
      end
      @(negedge clk);
      cyc++;
    end
    rvalid = 0; rdata = 32'hDEAD_BEEF; rresp = 2'b11;
    check({tag, "_latency"}, cyc, 3 + ar_wait + r_wait);
    take_resp(tag, exp_err, 0);
  endtask

  // Store with a scripted slave: awready at cycle aw_wait, wready at cycle w_wait.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input int aw_wait, input int w_wait,
                          input int b_wait, input logic [1:0] br, input int hold,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                          input logic exp_err);
    int cyc;
    int n;
    exp_q.push_back(32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_wen = 1; req_addr = addr; req_size = size; req_unsigned = 0;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_wen = 0; req_wdata = 32'h0;
    cyc = 1;
    n = ((aw_wait > w_wait) ? aw_wait : w_wait) + 1;
    for (int k = 0; k < n; k++) begin
      check({tag, "_awvalid"}, {31'd0, awvalid}, {31'd0, (k <= aw_wait)});
      check({tag, "_wvalid"}, {31'd0, wvalid}, {31'd0, (k <= w_wait)});
      check({tag, "_awaddr"}, awaddr, {addr[31:2], 2'b00});
      check({tag, "_wdata"}, wdata, exp_wdata);
      check({tag, "_wstrb"}, {28'd0, wstrb}, {28'd0, exp_strb});
      awready = (k == aw_wait);
      wready  = (k == w_wait);
      @(negedge clk);
      cyc++;
    end
    awready = 0; wready = 0;
    for (int k = 0; k <= b_wait; k++) begin
      check({tag, "_bready"}, {29'd0, bready, awvalid, wvalid}, 32'd4);
      if (k == b_wait) begin
        bvalid = 1; bresp = br;
      end
      @(negedge clk);
      cyc++;
    end
    bvalid = 0; bresp = 2'b11;
    check({tag, "_latency"}, cyc, 2 + n + b_wait);
    take_resp(tag, exp_err, hold);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst = 0;
    repeat (3) @(negedge clk);
    // reset state
    check_idle("reset");
    check("reset_araddr", araddr, 32'd0);
    check("reset_awaddr", awaddr, 32'd0);
    check("reset_wdata", wdata, 32'd0);
    check("reset_wstrb", {28'd0, wstrb}, 32'd0);
    check("reset_resp", {resp_rdata[30:0], resp_err}, 32'd0);
    rst = 1;
    @(negedge clk);

    // loads
    do_load("ld_word",   32'h8000_0000, 2'd2, 1'b0, 32'h1234_5678, 2'b00, 0, 0, 32'h1234_5678, 1'b0);
    do_load("ld_byte_s", 32'h8000_0003, 2'd0, 1'b0, 32'h80AA_BBCC, 2'b00, 0, 0, 32'hFFFF_FF80, 1'b0);
    do_load("ld_byte_u", 32'h8000_0003, 2'd0, 1'b1, 32'h80AA_BBCC, 2'b00, 0, 0, 32'h0000_0080, 1'b0);
    do_load("ld_half_s", 32'h8000_0002, 2'd1, 1'b0, 32'h9ABC_1234, 2'b00, 2, 1, 32'hFFFF_9ABC, 1'b0);
    do_load("ld_half_u", 32'h8000_0000, 2'd1, 1'b1, 32'h1234_F00F, 2'b00, 1, 0, 32'h0000_F00F, 1'b0);
    do_load("ld_size3",  32'h8000_0004, 2'd3, 1'b1, 32'h8765_4321, 2'b00, 0, 2, 32'h8765_4321, 1'b0);
    do_load("ld_rerr",   32'h8000_000C, 2'd2, 1'b0, 32'h55AA_55AA, 2'b10, 0, 0, 32'h55AA_55AA, 1'b1);

    // stores
    do_store("st_half",  32'h8000_0002, 2'd1, 32'h0000_ABCD, 0, 1, 0, 2'b00, 0,
             32'hABCD_0000, 4'b1100, 1'b0);
    do_store("st_berr",  32'h8000_0008, 2'd2, 32'hCAFE_F00D, 0, 0, 0, 2'b10, 5,
             32'hCAFE_F00D, 4'b1111, 1'b1);
    do_store("st_byte",  32'h8000_0001, 2'd0, 32'h1122_33EE, 2, 0, 1, 2'b00, 0,
             32'h2233_EE00, 4'b0010, 1'b0);

`ifdef LSU_MISALIGN_CHECK_EN
    // misaligned word load is rejected without touching the bus
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0001; req_size = 2'd2; req_unsigned = 0;
    @(negedge clk);
    req_valid = 0;
    check("mis_arvalid", {31'd0, arvalid}, 32'd0);
    exp_q.push_back(32'd0);
    take_resp("mis_ld", 1'b1, 0);
`else
    // misaligned requests go out with truncated shift/strobe
    do_load("mis_ld", 32'h8000_0001, 2'd2, 1'b0, 32'h1122_3344, 2'b00, 0, 0, 32'h0011_2233, 1'b0);
    do_store("mis_st", 32'h8000_0003, 2'd2, 32'hAABB_CCDD, 0, 0, 0, 2'b00, 0,
             32'hDD00_0000, 4'b1000, 1'b0);
`endif

    // reset while in R with rvalid pending
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0010; req_size = 2'd2; req_unsigned = 0;
    @(negedge clk);
    req_valid = 0; arready = 1;
    @(negedge clk);
    arready = 0;
    check("rst_mid_rready", {31'd0, rready}, 32'd1);
    rvalid = 1; rdata = 32'h0BAD_0BAD; rst = 0;
    @(negedge clk);
    rst = 1; rvalid = 0;
    check_idle("rst_mid");
    check("rst_mid_resp_rdata", resp_rdata, 32'd0);
    do_load("post_rst", 32'h8000_0020, 2'd2, 1'b0, 32'hA5A5_0F0F, 2'b00, 0, 0, 32'hA5A5_0F0F, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
